// File: rtl/multi_pulse_generator.sv
// Multi-channel pulse-train generator: per-channel programmable delay, width, gap and repeat
// count, with a shared power-up hold-off that gates acceptance of start requests.
module multi_pulse_generator #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned RESET_DELAY = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       abort,
  input  logic [NUM_CH*CNT_W-1:0] cfg_delay,
  input  logic [NUM_CH*CNT_W-1:0] cfg_width,
  input  logic [NUM_CH*CNT_W-1:0] cfg_gap,
  input  logic [NUM_CH*CNT_W-1:0] cfg_count,
  output logic                    ready,
  output logic [NUM_CH-1:0]       pulse_out,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  typedef enum logic [1:0] {StIdle, StDelay, StHigh, StGap} state_e;

  localparam int unsigned HoldW = $clog2(RESET_DELAY + 1);

  logic [HoldW-1:0] hold_q;
  state_e           state_q [NUM_CH];
  logic [CNT_W-1:0] tmr_q   [NUM_CH];
  logic [CNT_W-1:0] width_q [NUM_CH];
  logic [CNT_W-1:0] gap_q   [NUM_CH];
  logic [CNT_W-1:0] count_q [NUM_CH];
  logic [CNT_W-1:0] pcnt_q  [NUM_CH];

  // Timers hold "cycles remaining minus one", so a zero field clamps to a single cycle.
  function automatic logic [CNT_W-1:0] minus1_clamped(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      ready  <= 1'b0;
    end else if (!ready) begin
      hold_q <= hold_q + 1'b1;
      if (hold_q == HoldW'(RESET_DELAY - 1)) begin
        ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_out <= '0;
      busy      <= '0;
      done      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= StIdle;
        tmr_q[i]   <= '0;
        width_q[i] <= '0;
        gap_q[i]   <= '0;
        count_q[i] <= '0;
        pcnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        done[i] <= 1'b0;
        if (state_q[i] != StIdle && abort[i]) begin
          state_q[i]   <= StIdle;
          pulse_out[i] <= 1'b0;
          busy[i]      <= 1'b0;
        end else begin
          unique case (state_q[i])
            StIdle: begin
              if (start[i] && ready && !abort[i]) begin
                tmr_q[i]   <= minus1_clamped(cfg_delay[i*CNT_W +: CNT_W]);
                width_q[i] <= minus1_clamped(cfg_width[i*CNT_W +: CNT_W]);
                gap_q[i]   <= minus1_clamped(cfg_gap[i*CNT_W +: CNT_W]);
                count_q[i] <= cfg_count[i*CNT_W +: CNT_W];
                pcnt_q[i]  <= '0;
                busy[i]    <= 1'b1;
                state_q[i] <= StDelay;
              end
            end
            StDelay: begin
              if (tmr_q[i] == '0) begin
                state_q[i]   <= StHigh;
                pulse_out[i] <= 1'b1;
                tmr_q[i]     <= width_q[i];
              end else begin
                tmr_q[i] <= tmr_q[i] - 1'b1;
              end
            end
            StHigh: begin
              if (tmr_q[i] == '0) begin
                pulse_out[i] <= 1'b0;
                // A zero count means continuous: the pulse counter is free-running.
                if (count_q[i] != '0 && pcnt_q[i] == count_q[i] - 1'b1) begin
                  state_q[i] <= StIdle;
                  busy[i]    <= 1'b0;
                  done[i]    <= 1'b1;
                end else begin
                  state_q[i] <= StGap;
                  tmr_q[i]   <= gap_q[i];
                  pcnt_q[i]  <= pcnt_q[i] + 1'b1;
                end
              end else begin
                tmr_q[i] <= tmr_q[i] - 1'b1;
              end
            end
            StGap: begin
              if (tmr_q[i] == '0) begin
                state_q[i]   <= StHigh;
                pulse_out[i] <= 1'b1;
                tmr_q[i]     <= width_q[i];
              end else begin
                tmr_q[i] <= tmr_q[i] - 1'b1;
              end
            end
            default: state_q[i] <= StIdle;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Scoreboard bench: accepted trains are expanded into expected rise/fall/done edge times;
// a monitor pops and compares them as the outputs change, and checks ready/busy every cycle.
module tb_multi_pulse_generator;

  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int RD  = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NCH-1:0]    start = '0;
  logic [NCH-1:0]    abort = '0;
  logic [NCH*CW-1:0] cfg_delay = '0;
  logic [NCH*CW-1:0] cfg_width = '0;
  logic [NCH*CW-1:0] cfg_gap = '0;
  logic [NCH*CW-1:0] cfg_count = '0;
  logic              ready;
  logic [NCH-1:0]    pulse_out;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done;

  multi_pulse_generator #(
    .NUM_CH     (NCH),
    .CNT_W      (CW),
    .RESET_DELAY(RD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .cfg_delay(cfg_delay),
    .cfg_width(cfg_width),
    .cfg_gap  (cfg_gap),
    .cfg_count(cfg_count),
    .ready    (ready),
    .pulse_out(pulse_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;  // rising edges since reset release; edge 1 is the first

  // Expected events encoded as edge*4 + kind (0 rise, 1 fall, 2 done).
  int expq [NCH][$];
  int t_n [NCH];
  int t_end [NCH];
  int t_d [NCH];
  int t_w [NCH];
  int t_g [NCH];
  int t_c [NCH];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d required=%0d", name, cyc, got, exp);
    end
  endtask

  function automatic int max1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic bit busy_exp(input int ch, input int t);
    return t >= t_n[ch] && t < t_end[ch];
  endfunction

  // Expected pulse level after edge t from the train's arithmetic description.
  function automatic bit level_at(input int ch, input int t);
    int rel;
    if (!busy_exp(ch, t)) return 1'b0;
    rel = t - (t_n[ch] + t_d[ch]);
    if (rel < 0) return 1'b0;
    return (rel % (t_w[ch] + t_g[ch])) < t_w[ch];
  endfunction

  task automatic accept(input int ch, input int e);
    int k;
    int rise;
    t_n[ch] = e;
    t_d[ch] = max1(int'(cfg_delay[ch*CW +: CW]));
    t_w[ch] = max1(int'(cfg_width[ch*CW +: CW]));
    t_g[ch] = max1(int'(cfg_gap[ch*CW +: CW]));
    t_c[ch] = int'(cfg_count[ch*CW +: CW]);
    t_end[ch] = 1 << 30;
    k = 0;
    while (1) begin
      rise = e + t_d[ch] + k * (t_w[ch] + t_g[ch]);
      if (t_c[ch] != 0 && k >= t_c[ch]) break;
      if (t_c[ch] == 0 && rise > e + 400) break;
      expq[ch].push_back(rise * 4);
      expq[ch].push_back((rise + t_w[ch]) * 4 + 1);
      if (t_c[ch] != 0 && k == t_c[ch] - 1) begin
        expq[ch].push_back((rise + t_w[ch]) * 4 + 2);
        t_end[ch] = rise + t_w[ch];
      end
      k++;
    end
  endtask

  // Decide the effect of the currently driven inputs at the coming edge.
  task automatic apply_model();
    int e;
    bit hi;
    e = cyc + 1;
    for (int ch = 0; ch < NCH; ch++) begin
      if (abort[ch] && busy_exp(ch, e - 1)) begin
        hi = level_at(ch, e - 1);
        while (expq[ch].size() > 0 && expq[ch][$] / 4 >= e) void'(expq[ch].pop_back());
        if (hi) expq[ch].push_back(e * 4 + 1);
        t_end[ch] = e;
      end else if (start[ch] && !abort[ch] && (e - 1) >= RD && !busy_exp(ch, e - 1)) begin
        accept(ch, e);
      end
    end
  endtask

  task automatic tick();
    apply_model();
    @(posedge clk);
    #2;
    start = '0;
    abort = '0;
  endtask

  task automatic run_to(input int e);
    while (cyc + 1 < e) tick();
  endtask

  task automatic set_cfg(input int ch, input int d, input int w, input int g, input int c);
    cfg_delay[ch*CW +: CW] = CW'(d);
    cfg_width[ch*CW +: CW] = CW'(w);
    cfg_gap[ch*CW +: CW]   = CW'(g);
    cfg_count[ch*CW +: CW] = CW'(c);
  endtask

  task automatic clear_model();
    for (int ch = 0; ch < NCH; ch++) begin
      expq[ch].delete();
      t_n[ch] = 0;
      t_end[ch] = 0;
      t_d[ch] = 1;
      t_w[ch] = 1;
      t_g[ch] = 1;
      t_c[ch] = 0;
    end
  endtask

  task automatic observe(input int ch, input int kind);
    int v;
    if (expq[ch].size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event ch=%0d edge=%0d kind=%0d required=none", ch, cyc, kind);
    end else begin
      v = expq[ch].pop_front();
      chk($sformatf("event_ch%0d", ch), cyc * 4 + kind, v);
    end
  endtask

  // Monitor: samples 1 ns after each rising edge.
  logic [NCH-1:0] prev_p = '0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        cyc = 0;
        prev_p = '0;
      end else begin
        cyc++;
        chk("ready", int'(ready), int'(cyc >= RD));
        for (int ch = 0; ch < NCH; ch++) begin
          while (expq[ch].size() > 0 && expq[ch][0] / 4 < cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_event ch=%0d edge=%0d got=none required=%0d", ch, cyc,
                     expq[ch].pop_front());
          end
          if (pulse_out[ch] && !prev_p[ch]) observe(ch, 0);
          if (!pulse_out[ch] && prev_p[ch]) observe(ch, 1);
          if (done[ch]) observe(ch, 2);
          chk($sformatf("busy_ch%0d", ch), int'(busy[ch]), int'(busy_exp(ch, cyc)));
        end
        prev_p = pulse_out;
      end
    end
  end

  int n;

  initial begin
    clear_model();
    @(negedge clk);
    #1;
    chk("reset_outputs", int'({ready, pulse_out, busy, done}), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;

    // Start during the hold-off is dropped.
    set_cfg(0, 3, 5, 2, 1);
    run_to(5);
    start[0] = 1'b1;
    tick();

    // Single pulse, with a simultaneous start at the ready edge (dropped).
    run_to(RD);
    start[0] = 1'b1;
    tick();
    n = 20;
    run_to(n);
    start[0] = 1'b1;
    tick();
    set_cfg(0, 9, 9, 9, 9);  // changes while busy are ignored
    run_to(n + 12);

    // Three-pulse train with ignored retriggers.
    n = 40;
    set_cfg(0, 3, 5, 2, 3);
    run_to(n);
    start[0] = 1'b1;
    tick();
    run_to(n + 6);
    start[0] = 1'b1;
    tick();
    run_to(n + 12);
    start[0] = 1'b1;
    tick();
    run_to(n + 23);
    start[0] = 1'b1;  // restart right after done
    set_cfg(0, 1, 1, 1, 1);
    tick();
    run_to(n + 30);

    // Continuous mode aborted, then start+abort together in idle.
    n = 80;
    set_cfg(1, 1, 2, 2, 0);
    run_to(n);
    start[1] = 1'b1;
    tick();
    run_to(n + 20);
    abort[1] = 1'b1;
    tick();
    start[1] = 1'b1;
    abort[1] = 1'b1;
    tick();
    run_to(n + 30);

    // Both channels at the same edge, zero-clamped config and restart.
    n = 120;
    set_cfg(0, 0, 0, 0, 2);
    set_cfg(1, 4, 3, 0, 1);
    run_to(n);
    start = 2'b11;
    tick();
    run_to(n + 5);
    start[0] = 1'b1;
    tick();
    run_to(n + 15);

    // Asynchronous reset mid-pulse.
    set_cfg(0, 1, 20, 1, 1);
    set_cfg(1, 2, 20, 1, 0);
    start = 2'b11;
    tick();
    repeat (5) tick();
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset", int'({ready, pulse_out, busy, done}), 0);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;

    // Randomised traffic, including starts during the fresh hold-off.
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        set_cfg(ch, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 3));
        start[ch] = ($urandom_range(0, 7) == 0);
        abort[ch] = ($urandom_range(0, 39) == 0);
        if (t_c[ch] == 0 && busy_exp(ch, cyc) && cyc - t_n[ch] > 200) abort[ch] = 1'b1;
      end
      tick();
    end

    abort = 2'b11;
    tick();
    repeat (10) tick();
    for (int ch = 0; ch < NCH; ch++) chk($sformatf("drained_ch%0d", ch), expq[ch].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
